// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller:
// state encoding, change-coin codes, drink codes and default pricing.
package vend_pkg;

  typedef enum logic [0:0] {
    StInsert = 1'b0,
    StChange = 1'b1
  } vend_state_e;

  localparam logic [1:0] COIN5  = 2'b01;
  localparam logic [1:0] COIN10 = 2'b10;
  localparam logic [1:0] COIN50 = 2'b11;

  localparam logic [2:0] DRINK1 = 3'd1;
  localparam logic [2:0] DRINK2 = 3'd2;
  localparam logic [2:0] DRINK3 = 3'd3;
  localparam logic [2:0] DRINK4 = 3'd4;

  localparam int unsigned PRICE1_DEF  = 75;
  localparam int unsigned PRICE2_DEF  = 50;
  localparam int unsigned PRICE3_DEF  = 30;
  localparam int unsigned PRICE4_DEF  = 20;
  localparam int unsigned MAX_BAL_DEF = 100;

  // Largest returnable coin not exceeding the balance; callers guarantee bal >= 5.
  function automatic logic [1:0] greedy_coin(input logic [6:0] bal);
    if (bal >= 7'd50) begin
      return COIN50;
    end else if (bal >= 7'd10) begin
      return COIN10;
    end
    return COIN5;
  endfunction

  function automatic logic [6:0] coin_value(input logic [1:0] code);
    case (code)
      COIN5:   return 7'd5;
      COIN10:  return 7'd10;
      COIN50:  return 7'd50;
      default: return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_tick_gen.sv
// Free-running 0..TICK_CYCLES-1 counter producing a one-cycle pulse at each wrap.
// clr holds the count at zero so the first tick lands TICK_CYCLES cycles after release.
module vend_tick_gen #(
  parameter int unsigned TICK_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q + CntOne;
    if (clr || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  assign tick = (cnt_q == CntMax) && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: arbitrates coin/cancel/drink events, keeps the
// saturating balance, authorises purchases and pays change one coin per tick.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100000000,
  parameter int unsigned MAX_BAL     = MAX_BAL_DEF,
  parameter int unsigned PRICE1      = PRICE1_DEF,
  parameter int unsigned PRICE2      = PRICE2_DEF,
  parameter int unsigned PRICE3      = PRICE3_DEF,
  parameter int unsigned PRICE4      = PRICE4_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin5,
  input  logic       coin10,
  input  logic       coin50,
  input  logic       cancel,
  input  logic [2:0] drink_req,
  output logic [6:0] balance,
  output logic [3:0] affordable,
  output logic       vend_pulse,
  output logic [2:0] vend_id,
  output logic       deny_pulse,
  output logic       coin_valid,
  output logic [1:0] coin_code,
  output logic       busy
);

  localparam logic [6:0] MaxBal = 7'(MAX_BAL);
  localparam logic [6:0] P1     = 7'(PRICE1);
  localparam logic [6:0] P2     = 7'(PRICE2);
  localparam logic [6:0] P3     = 7'(PRICE3);
  localparam logic [6:0] P4     = 7'(PRICE4);

  function automatic logic [6:0] price_of(input logic [2:0] code);
    case (code)
      DRINK1:  return P1;
      DRINK2:  return P2;
      DRINK3:  return P3;
      DRINK4:  return P4;
      default: return 7'd0;
    endcase
  endfunction

  vend_state_e state_d, state_q;
  logic [6:0]  balance_d, balance_q;
  logic [2:0]  vend_id_d, vend_id_q;
  logic [1:0]  coin_code_d, coin_code_q;
  logic        vend_pulse_d, vend_pulse_q;
  logic        deny_pulse_d, deny_pulse_q;
  logic        coin_valid_d, coin_valid_q;
  logic [6:0]  coin_add;
  logic [7:0]  bal_sum;
  logic [1:0]  chg_code;
  logic        drink_valid;
  logic        tick;

  vend_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == StInsert),
    .tick (tick)
  );

  assign drink_valid = (drink_req != 3'd0) && (drink_req <= DRINK4);

  always_comb begin
    state_d      = state_q;
    balance_d    = balance_q;
    vend_id_d    = vend_id_q;
    coin_code_d  = coin_code_q;
    vend_pulse_d = 1'b0;
    deny_pulse_d = 1'b0;
    coin_valid_d = 1'b0;
    coin_add     = coin50 ? 7'd50 : (coin10 ? 7'd10 : 7'd5);
    // Sum in 8 bits so 95 + 50 saturates instead of wrapping.
    bal_sum      = {1'b0, balance_q} + {1'b0, coin_add};
    chg_code     = greedy_coin(balance_q);

    unique case (state_q)
      StInsert: begin
        if (cancel) begin
          state_d = StChange;
        end else if (drink_valid) begin
          if (balance_q >= price_of(drink_req)) begin
            balance_d    = balance_q - price_of(drink_req);
            vend_pulse_d = 1'b1;
            vend_id_d    = drink_req;
            state_d      = StChange;
          end else begin
            deny_pulse_d = 1'b1;
          end
        end else if (coin50 || coin10 || coin5) begin
          balance_d = (bal_sum > {1'b0, MaxBal}) ? MaxBal : bal_sum[6:0];
        end
      end
      StChange: begin
        if (tick) begin
          if (balance_q == 7'd0) begin
            state_d = StInsert;
          end else begin
            coin_valid_d = 1'b1;
            coin_code_d  = chg_code;
            balance_d    = balance_q - coin_value(chg_code);
          end
        end
      end
      default: state_d = StInsert;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInsert;
      balance_q    <= 7'd0;
      vend_id_q    <= 3'd0;
      coin_code_q  <= 2'd0;
      vend_pulse_q <= 1'b0;
      deny_pulse_q <= 1'b0;
      coin_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      balance_q    <= balance_d;
      vend_id_q    <= vend_id_d;
      coin_code_q  <= coin_code_d;
      vend_pulse_q <= vend_pulse_d;
      deny_pulse_q <= deny_pulse_d;
      coin_valid_q <= coin_valid_d;
    end
  end

  assign balance    = balance_q;
  assign vend_id    = vend_id_q;
  assign coin_code  = coin_code_q;
  assign vend_pulse = vend_pulse_q;
  assign deny_pulse = deny_pulse_q;
  assign coin_valid = coin_valid_q;
  assign busy       = (state_q == StChange);
  assign affordable = (state_q == StInsert) ?
                      {balance_q >= P4, balance_q >= P3, balance_q >= P2, balance_q >= P1} :
                      4'b0000;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Self-checking bench for vend_txn_ctrl: vector table, directed change sequences and
// random traffic, all compared against a queue-based transaction model.
module tb_vend_txn_ctrl;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin5 = 1'b0, coin10 = 1'b0, coin50 = 1'b0, cancel = 1'b0;
  logic [2:0] drink_req = 3'd0;
  logic [6:0] balance;
  logic [3:0] affordable;
  logic       vend_pulse, deny_pulse, coin_valid, busy;
  logic [2:0] vend_id;
  logic [1:0] coin_code;

  vend_txn_ctrl #(
    .TICK_CYCLES(T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coin5     (coin5),
    .coin10    (coin10),
    .coin50    (coin50),
    .cancel    (cancel),
    .drink_req (drink_req),
    .balance   (balance),
    .affordable(affordable),
    .vend_pulse(vend_pulse),
    .vend_id   (vend_id),
    .deny_pulse(deny_pulse),
    .coin_valid(coin_valid),
    .coin_code (coin_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int price [5] = '{0, 75, 50, 30, 20};

  // Model: balance, change mode, cycles since entering change, pending refund coins.
  int m_bal, m_t, e_vid, e_code;
  bit m_chg, e_vend, e_deny, e_cv;
  int m_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bal = 0; m_t = 0; m_chg = 0; m_q.delete();
    e_vid = 0; e_code = 0; e_vend = 0; e_deny = 0; e_cv = 0;
  endtask

  task automatic enter_change();
    int r;
    m_chg = 1; m_t = 0; m_q.delete();
    r = m_bal;
    while (r >= 50) begin m_q.push_back(50); r -= 50; end
    while (r >= 10) begin m_q.push_back(10); r -= 10; end
    while (r >= 5)  begin m_q.push_back(5);  r -= 5;  end
  endtask

  task automatic model_update(input bit c5, c10, c50, can, input int dr);
    int v;
    e_vend = 0; e_deny = 0; e_cv = 0;
    if (m_chg) begin
      m_t++;
      if (m_t % T == 0) begin
        if (m_q.size() > 0) begin
          v = m_q.pop_front();
          m_bal -= v; e_cv = 1;
          e_code = (v == 50) ? 3 : ((v == 10) ? 2 : 1);
        end else begin
          m_chg = 0;
        end
      end
    end else if (can) begin
      enter_change();
    end else if (dr >= 1 && dr <= 4) begin
      if (m_bal >= price[dr]) begin
        m_bal -= price[dr]; e_vend = 1; e_vid = dr;
        enter_change();
      end else begin
        e_deny = 1;
      end
    end else if (c50 || c10 || c5) begin
      m_bal += c50 ? 50 : (c10 ? 10 : 5);
      if (m_bal > 100) m_bal = 100;
    end
  endtask

  function automatic int model_aff();
    int a = 0;
    if (!m_chg) for (int i = 0; i < 4; i++) if (m_bal >= price[i+1]) a |= (1 << i);
    return a;
  endfunction

  task automatic check_model();
    chk("balance", balance, m_bal);
    chk("busy", busy, m_chg);
    chk("affordable", affordable, model_aff());
    chk("vend_pulse", vend_pulse, e_vend);
    chk("vend_id", vend_id, e_vid);
    chk("deny_pulse", deny_pulse, e_deny);
    chk("coin_valid", coin_valid, e_cv);
    chk("coin_code", coin_code, e_code);
  endtask

  task automatic step(input bit c5, c10, c50, can, input int dr);
    coin5 = c5; coin10 = c10; coin50 = c50; cancel = can; drink_req = 3'(dr);
    @(posedge clk);
    model_update(c5, c10, c50, can, dr);
    #1;
    coin5 = 0; coin10 = 0; coin50 = 0; cancel = 0; drink_req = 3'd0;
    check_model();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit rst;
    bit c5, c10, c50, can;
    int dr;
    int bal;
    int aff;
    bit vend, deny, busy;
  } vec_t;

  vec_t tbl[$];
  int   coin_at[$];
  int   code_at[$];
  int   exp_codes2 [5] = '{2, 2, 2, 2, 1};

  initial begin
    model_reset();
    #7;
    rst_n = 1'b1;

    tbl.push_back('{1, 0, 0, 0, 0, 0,   0, 4'b0000, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0,  50, 4'b1110, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0,  60, 4'b1110, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0,  70, 4'b1110, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0,  75, 4'b1111, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 100, 4'b1111, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 100, 4'b1111, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 7, 100, 4'b1111, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 0, 0, 0,  10, 4'b0000, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 0,  60, 4'b1110, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 5,  60, 4'b1110, 0, 0, 0});
    tbl.push_back('{1, 0, 1, 0, 0, 0,  10, 4'b0000, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0,  20, 4'b1000, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1,  20, 4'b1000, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 1,  20, 4'b1000, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 4,   0, 4'b0000, 1, 0, 1});

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].c5, tbl[i].c10, tbl[i].c50, tbl[i].can, tbl[i].dr);
      chk("tbl_balance", balance, tbl[i].bal);
      chk("tbl_affordable", affordable, tbl[i].aff);
      chk("tbl_vend", vend_pulse, tbl[i].vend);
      chk("tbl_deny", deny_pulse, tbl[i].deny);
      chk("tbl_busy", busy, tbl[i].busy);
    end

    // Purchase of drink 3 from 75, then 45 returned as 10,10,10,10,5 one tick apart.
    do_reset();
    step(0, 0, 1, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
    chk("t2_afford", affordable, 15);
    step(0, 0, 0, 0, 3);
    chk("t2_vend", vend_pulse, 1);
    chk("t2_vend_id", vend_id, 3);
    chk("t2_balance", balance, 45);
    chk("t2_busy", busy, 1);
    coin_at.delete(); code_at.delete();
    for (int i = 1; i <= 24; i++) begin
      idle();
      if (coin_valid) begin coin_at.push_back(i); code_at.push_back(coin_code); end
      if (i == 23) chk("t2_busy_before_return", busy, 1);
      if (i == 24) chk("t2_busy_after_return", busy, 0);
    end
    chk("t2_coin_count", coin_at.size(), 5);
    for (int j = 0; j < 5 && j < coin_at.size(); j++) begin
      chk("t2_coin_cycle", coin_at[j], 4 * (j + 1));
      chk("t2_coin_code", code_at[j], exp_codes2[j]);
    end
    chk("t2_final_balance", balance, 0);

    // Cancel beats a same-cycle coin; coins during change are discarded.
    do_reset();
    step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    chk("t5_balance", balance, 15);
    chk("t5_busy", busy, 1);
    coin_at.delete(); code_at.delete();
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, (i == 2 || i == 6), 0, 0);
      if (coin_valid) begin coin_at.push_back(i); code_at.push_back(coin_code); end
    end
    chk("t5_coin_count", coin_at.size(), 2);
    if (coin_at.size() == 2) begin
      chk("t5_first_coin", coin_at[0] * 4 + code_at[0], 4 * 4 + 2);
      chk("t5_second_coin", coin_at[1] * 4 + code_at[1], 8 * 4 + 1);
    end
    chk("t5_busy_end", busy, 0);
    chk("t5_balance_end", balance, 0);

    // Reset mid-change after one coin: balance 95 -> 50 returned -> 45, then reset.
    do_reset();
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("t6_balance_pre", balance, 95);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) idle();
    chk("t6_balance_mid", balance, 45);
    chk("t6_coin_code_mid", coin_code, 3);
    do_reset();
    chk("t6_rst_busy", busy, 0);
    for (int i = 0; i < 8; i++) idle();
    chk("t6_idle_busy", busy, 0);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 29) == 0,
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
